// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-side operands and WB bypass inputs in, registered EX-side copies out.
// master drives the ID/WB side and observes EX; slave is the pipeline register itself.
interface id_ex_reg_if #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 4
);
    localparam int unsigned CTRL_W = ALUOP_W + 6;

    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DEPTH-1:0]  id_imm;
    logic [1:0]        id_imm_sel;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [CTRL_W-1:0] id_ctrl;

    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_imm_sel,
               id_rs, id_rt, id_rd, id_ctrl, wb_we, wb_addr, wb_data,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_imm_sel,
               id_rs, id_rt, id_rd, id_ctrl, wb_we, wb_addr, wb_data,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_ctrl
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register: immediate build, WB->ID same-cycle bypass, stall hold and flush bubble.
// Edge priority is flush > stall > load; every output is a flop.
module id_ex_reg #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    id_ex_reg_if.slave   bus
);
    localparam int unsigned CTRL_W = ALUOP_W + 6;
    localparam int unsigned PAD_W  = DATA_W - DEPTH;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              rs_hit;
    logic              rt_hit;

    // Immediate formatting selected by the decoder
    always_comb begin
        imm_ext = '0;
        case (bus.id_imm_sel)
            2'b00:   imm_ext = {{PAD_W{1'b0}}, bus.id_imm};
            2'b01:   imm_ext = {{PAD_W{bus.id_imm[DEPTH-1]}}, bus.id_imm};
            2'b10:   imm_ext = {bus.id_imm, {PAD_W{1'b0}}};
            default: imm_ext = DATA_W'(bus.id_imm[10:6]);
        endcase
    end

    // A register written by WB this cycle is read stale from the file; r0 is hardwired zero
    always_comb begin
        rs_hit = bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rs);
        rt_hit = bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rt);
        rs_fwd = rs_hit ? bus.wb_data : bus.id_rs_data;
        rt_fwd = rt_hit ? bus.wb_data : bus.id_rt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc4     <= '0;
            bus.ex_rs_data <= '0;
            bus.ex_rt_data <= '0;
            bus.ex_imm     <= '0;
            bus.ex_rs      <= '0;
            bus.ex_rt      <= '0;
            bus.ex_rd      <= '0;
            bus.ex_ctrl    <= '0;
        end else if (flush) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc4     <= '0;
            bus.ex_rs_data <= '0;
            bus.ex_rt_data <= '0;
            bus.ex_imm     <= '0;
            bus.ex_rs      <= '0;
            bus.ex_rt      <= '0;
            bus.ex_rd      <= '0;
            bus.ex_ctrl    <= '0;
        end else if (!stall) begin
            bus.ex_valid   <= bus.id_valid;
            bus.ex_pc4     <= bus.id_pc4;
            bus.ex_rs_data <= rs_fwd;
            bus.ex_rt_data <= rt_fwd;
            bus.ex_imm     <= imm_ext;
            bus.ex_rs      <= bus.id_rs;
            bus.ex_rt      <= bus.id_rt;
            bus.ex_rd      <= bus.id_rd;
            // An invalid slot must not carry side effects into EX
            bus.ex_ctrl    <= bus.id_valid ? bus.id_ctrl : CTRL_W'(0);
        end
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed corner cases followed by randomized traffic
// compared against an arithmetic reference model of the EX-side registers.
module tb_id_ex_reg;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned CTRL_W  = ALUOP_W + 6;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    id_ex_reg_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) bus ();

    id_ex_reg #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what EX should hold
    logic              e_valid;
    logic [DATA_W-1:0] e_pc4, e_rs_data, e_rt_data, e_imm;
    logic [REG_AW-1:0] e_rs, e_rt, e_rd;
    logic [CTRL_W-1:0] e_ctrl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] sel);
        int unsigned v;
        v = int'(imm);
        case (sel)
            2'd0:    return v;
            2'd1:    return (v >= 32768) ? v + 32'hFFFF_0000 : v;
            2'd2:    return v * 65536;
            default: return (v / 64) % 32;
        endcase
    endfunction

    task automatic model_clear();
        e_valid = 1'b0; e_pc4 = '0; e_rs_data = '0; e_rt_data = '0; e_imm = '0;
        e_rs = '0; e_rt = '0; e_rd = '0; e_ctrl = '0;
    endtask

    // Apply the edge rules to the inputs currently presented
    task automatic model_edge();
        if (flush) model_clear();
        else if (!stall) begin
            e_valid   = bus.id_valid;
            e_pc4     = bus.id_pc4;
            e_rs_data = (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == bus.id_rs) ? bus.wb_data : bus.id_rs_data;
            e_rt_data = (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == bus.id_rt) ? bus.wb_data : bus.id_rt_data;
            e_imm     = ref_imm(bus.id_imm, bus.id_imm_sel);
            e_rs      = bus.id_rs;
            e_rt      = bus.id_rt;
            e_rd      = bus.id_rd;
            e_ctrl    = bus.id_valid ? bus.id_ctrl : '0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(bus.ex_valid),   32'(e_valid));
        chk({tag, ".pc4"},     bus.ex_pc4,          e_pc4);
        chk({tag, ".rs_data"}, bus.ex_rs_data,      e_rs_data);
        chk({tag, ".rt_data"}, bus.ex_rt_data,      e_rt_data);
        chk({tag, ".imm"},     bus.ex_imm,          e_imm);
        chk({tag, ".rs"},      32'(bus.ex_rs),      32'(e_rs));
        chk({tag, ".rt"},      32'(bus.ex_rt),      32'(e_rt));
        chk({tag, ".rd"},      32'(bus.ex_rd),      32'(e_rd));
        chk({tag, ".ctrl"},    32'(bus.ex_ctrl),    32'(e_ctrl));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_inputs();
        bus.id_valid   = ($urandom_range(0, 3) != 0);
        bus.id_pc4     = $urandom;
        bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom;
        bus.id_imm     = 16'($urandom);
        bus.id_imm_sel = 2'($urandom);
        bus.id_rs      = 5'($urandom);
        bus.id_rt      = 5'($urandom);
        bus.id_rd      = 5'($urandom);
        bus.id_ctrl    = 10'($urandom);
        bus.wb_we      = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       bus.wb_addr = bus.id_rs;
            1:       bus.wb_addr = bus.id_rt;
            2:       bus.wb_addr = 5'd0;
            default: bus.wb_addr = 5'($urandom);
        endcase
        bus.wb_data    = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Immediate formats
        rand_inputs();
        bus.id_valid = 1'b1; bus.id_imm = 16'h8001;
        bus.id_imm_sel = 2'b00; step("imm00"); chk("imm00_lit", bus.ex_imm, 32'h0000_8001);
        bus.id_imm_sel = 2'b01; step("imm01"); chk("imm01_lit", bus.ex_imm, 32'hFFFF_8001);
        bus.id_imm_sel = 2'b10; step("imm10"); chk("imm10_lit", bus.ex_imm, 32'h8001_0000);
        bus.id_imm_sel = 2'b11; step("imm11"); chk("imm11_lit", bus.ex_imm, 32'h0000_0000);
        bus.id_imm = 16'h07C0;  step("imm11b"); chk("imm11b_lit", bus.ex_imm, 32'h0000_001F);

        // Stall holds through changing inputs
        rand_inputs(); bus.id_pc4 = 32'h104; step("load104");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("stall");
            chk("stall_pc4_lit", bus.ex_pc4, 32'h104);
        end

        // Flush wins over stall
        rand_inputs(); bus.id_valid = 1'b1; bus.id_ctrl = '1; flush = 1'b1;
        step("flush_stall");
        chk("flush_valid_lit", 32'(bus.ex_valid), 32'd0);
        chk("flush_ctrl_lit", 32'(bus.ex_ctrl), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // WB bypass, r0 excluded, rt untouched
        rand_inputs();
        bus.id_rs = 5'd5; bus.id_rt = 5'd6; bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h33;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h22;
        step("byp");
        chk("byp_rs_lit", bus.ex_rs_data, 32'h22);
        chk("byp_rt_lit", bus.ex_rt_data, 32'h33);
        bus.id_rs = 5'd0; bus.wb_addr = 5'd0;
        step("byp_r0");
        chk("byp_r0_lit", bus.ex_rs_data, 32'h11);

        // Invalid slot drops control
        rand_inputs(); bus.id_valid = 1'b0; bus.id_ctrl = '1;
        step("invalid");
        chk("invalid_ctrl_lit", 32'(bus.ex_ctrl), 32'd0);

        // Async reset between edges, asserted mid-stall
        rand_inputs(); bus.id_valid = 1'b1; step("pre_rst");
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        rand_inputs();
        step("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
